// File: rtl/niosii_system_sysid_checker_pkg.sv
// Shared types and constants for the sysid checker: FSM states, CSR map and bit positions.
package niosii_system_sysid_checker_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_ID = 2'd1,
      RD_TS = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] CSR_STATUS      = 2'd0;
   localparam logic [1:0] CSR_CAPTURED_ID = 2'd1;
   localparam logic [1:0] CSR_CAPTURED_TS = 2'd2;
   localparam logic [1:0] CSR_CONTROL     = 2'd3;

   localparam int STATUS_DONE    = 0;
   localparam int STATUS_PASS    = 1;
   localparam int STATUS_ID_MIS  = 2;
   localparam int STATUS_TS_MIS  = 3;
   localparam int STATUS_TIMEOUT = 4;
   localparam int STATUS_IRQ     = 5;

   localparam int CTRL_RESTART   = 0;
   localparam int CTRL_IRQ_CLEAR = 1;

   function automatic logic [31:0] status_word(input logic done, input logic pass,
                                                input logic id_mis, input logic ts_mis,
                                                input logic timeout, input logic irq);
      logic [31:0] w;
      w                 = '0;
      w[STATUS_DONE]    = done;
      w[STATUS_PASS]    = pass;
      w[STATUS_ID_MIS]  = id_mis;
      w[STATUS_TS_MIS]  = ts_mis;
      w[STATUS_TIMEOUT] = timeout;
      w[STATUS_IRQ]     = irq;
      return w;
   endfunction

endpackage

// File: rtl/niosii_system_sysid_checker_timeout.sv
// Loadable 16-bit up/down counter with clear, enable and a terminal-count compare.
module niosii_system_sysid_checker_timeout (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        en,
   input  logic        down,
   input  logic [15:0] tc_value,
   output logic        tc
);
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_value;
      end else if (en) begin
         count_d = down ? (count_q - 16'd1) : (count_q + 16'd1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == tc_value);

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Boot-time sysid checker: reads the sysid ID and timestamp words over Avalon-MM, compares
// them with build-time values and reports the verdict through a small CSR slave and irq.
module niosii_system_sysid_checker
   import niosii_system_sysid_checker_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h589F867B,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter int unsigned RECHECK_PERIOD     = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        m_address,
   output logic        m_read,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   input  logic [1:0]  s_address,
   input  logic        s_read,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic        check_done,
   output logic        check_pass,
   output logic        irq
);
   localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT_CYCLES);
   // Recheck fires on the edge where the DONE-cycle count would reach RECHECK_PERIOD.
   localparam logic [15:0] RECHECK_TC = 16'((RECHECK_PERIOD == 0) ? 0 : RECHECK_PERIOD - 1);
   localparam logic        RECHECK_EN = (RECHECK_PERIOD != 0);

   state_t      state_q, state_d;
   logic [31:0] id_q, id_d, ts_q, ts_d;
   logic        done_q, done_d, pass_q, pass_d;
   logic        id_mis_q, id_mis_d, ts_mis_q, ts_mis_d;
   logic        timeout_q, timeout_d, irq_q, irq_d;
   logic        rd_active, in_done, ctrl_write, restart, irq_clear, fail_entry;
   logic        timeout_hit, recheck_hit, unused_inputs;

   assign rd_active     = (state_q == RD_ID) || (state_q == RD_TS);
   assign in_done       = (state_q == DONE);
   assign ctrl_write    = s_write && (s_address == CSR_CONTROL);
   assign irq_clear     = ctrl_write && s_writedata[CTRL_IRQ_CLEAR];
   assign restart       = (ctrl_write && s_writedata[CTRL_RESTART]) ||
                          (RECHECK_EN && recheck_hit && in_done);
   assign unused_inputs = ^{s_read, s_writedata[31:2]};

   niosii_system_sysid_checker_timeout u_timeout (
      .clock      (clock),
      .reset_n    (reset_n),
      .clr        (state_d != state_q),
      .load       (1'b0),
      .load_value (16'd0),
      .en         (rd_active && m_waitrequest),
      .down       (1'b0),
      .tc_value   (TIMEOUT_TC),
      .tc         (timeout_hit)
   );

   niosii_system_sysid_checker_timeout u_recheck (
      .clock      (clock),
      .reset_n    (reset_n),
      .clr        (!in_done || (state_d != DONE)),
      .load       (1'b0),
      .load_value (16'd0),
      .en         (in_done),
      .down       (1'b0),
      .tc_value   (RECHECK_TC),
      .tc         (recheck_hit)
   );

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      ts_d       = ts_q;
      done_d     = done_q;
      pass_d     = pass_q;
      id_mis_d   = id_mis_q;
      ts_mis_d   = ts_mis_q;
      timeout_d  = timeout_q;
      fail_entry = 1'b0;
      m_read     = 1'b0;
      m_address  = 1'b0;
      case (state_q)
         IDLE: state_d = RD_ID;
         RD_ID: begin
            m_read = 1'b1;
            if (!m_waitrequest) begin
               id_d    = m_readdata;
               state_d = RD_TS;
            end else if (timeout_hit) begin
               state_d    = DONE;
               done_d     = 1'b1;
               pass_d     = 1'b0;
               timeout_d  = 1'b1;
               id_mis_d   = (id_q != EXPECTED_ID);
               fail_entry = 1'b1;
            end
         end
         RD_TS: begin
            m_read    = 1'b1;
            m_address = 1'b1;
            if (!m_waitrequest) begin
               ts_d       = m_readdata;
               state_d    = DONE;
               done_d     = 1'b1;
               id_mis_d   = (id_q != EXPECTED_ID);
               ts_mis_d   = (m_readdata != EXPECTED_TIMESTAMP);
               pass_d     = !id_mis_d && !ts_mis_d;
               fail_entry = !pass_d;
            end else if (timeout_hit) begin
               // The timestamp was never read, so only the ID comparison is meaningful.
               state_d    = DONE;
               done_d     = 1'b1;
               pass_d     = 1'b0;
               timeout_d  = 1'b1;
               id_mis_d   = (id_q != EXPECTED_ID);
               fail_entry = 1'b1;
            end
         end
         DONE: begin
            if (restart) begin
               state_d   = RD_ID;
               id_d      = '0;
               ts_d      = '0;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               id_mis_d  = 1'b0;
               ts_mis_d  = 1'b0;
               timeout_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // A failing DONE entry outranks a simultaneous clear.
      irq_d = irq_q;
      if (irq_clear) begin
         irq_d = 1'b0;
      end
      if (fail_entry) begin
         irq_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         id_q      <= '0;
         ts_q      <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         id_mis_q  <= 1'b0;
         ts_mis_q  <= 1'b0;
         timeout_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         ts_q      <= ts_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         id_mis_q  <= id_mis_d;
         ts_mis_q  <= ts_mis_d;
         timeout_q <= timeout_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      s_readdata = '0;
      case (s_address)
         CSR_STATUS:      s_readdata = status_word(done_q, pass_q, id_mis_q, ts_mis_q,
                                                   timeout_q, irq_q);
         CSR_CAPTURED_ID: s_readdata = id_q;
         CSR_CAPTURED_TS: s_readdata = ts_q;
         default:         s_readdata = '0;
      endcase
   end

   assign check_done = done_q;
   assign check_pass = pass_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Self-checking bench: two checker instances (default and short-timeout/auto-recheck) driven by a
// stalling sysid slave model; results are predicted from stall counts and returned words.
module tb_niosii_system_sysid_checker;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'h589F867B;
   localparam int TA = 255;
   localparam int TB = 4;
   localparam int PB = 10;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n = 1'b0;
   logic [31:0] id_word = EXP_ID;
   logic [31:0] ts_word = EXP_TS;

   logic        a_m_address, a_m_read, a_m_wait, a_done, a_pass, a_irq;
   logic [31:0] a_m_rdata, a_s_rdata;
   logic [1:0]  a_s_address = 2'd0;
   logic        a_s_read = 1'b0, a_s_write = 1'b0;
   logic [31:0] a_s_wdata = 32'd0;
   int          a_stall_id = 0, a_stall_ts = 0, a_cnt = 0;

   logic        b_m_address, b_m_read, b_m_wait, b_done, b_pass, b_irq;
   logic [31:0] b_m_rdata, b_s_rdata;
   logic [1:0]  b_s_address = 2'd0;
   logic        b_s_read = 1'b0, b_s_write = 1'b0;
   logic [31:0] b_s_wdata = 32'd0;
   int          b_stall_id = 0, b_stall_ts = 0, b_cnt = 0;

   int   n_cmp = 0, n_mis = 0;
   logic irq_a = 1'b0, irq_b = 1'b0;

   niosii_system_sysid_checker u_dut_a (
      .clock(clock), .reset_n(reset_n), .m_address(a_m_address), .m_read(a_m_read),
      .m_waitrequest(a_m_wait), .m_readdata(a_m_rdata), .s_address(a_s_address),
      .s_read(a_s_read), .s_write(a_s_write), .s_writedata(a_s_wdata),
      .s_readdata(a_s_rdata), .check_done(a_done), .check_pass(a_pass), .irq(a_irq));

   niosii_system_sysid_checker #(.TIMEOUT_CYCLES(TB), .RECHECK_PERIOD(PB)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .m_address(b_m_address), .m_read(b_m_read),
      .m_waitrequest(b_m_wait), .m_readdata(b_m_rdata), .s_address(b_s_address),
      .s_read(b_s_read), .s_write(b_s_write), .s_writedata(b_s_wdata),
      .s_readdata(b_s_rdata), .check_done(b_done), .check_pass(b_pass), .irq(b_irq));

   // sysid slave models: each read stalls for the programmed number of cycles
   assign a_m_wait  = a_m_read && (a_cnt < (a_m_address ? a_stall_ts : a_stall_id));
   assign a_m_rdata = a_m_address ? ts_word : id_word;
   always @(posedge clock) a_cnt <= (a_m_read && a_m_wait) ? a_cnt + 1 : 0;
   assign b_m_wait  = b_m_read && (b_cnt < (b_m_address ? b_stall_ts : b_stall_id));
   assign b_m_rdata = b_m_address ? ts_word : id_word;
   always @(posedge clock) b_cnt <= (b_m_read && b_m_wait) ? b_cnt + 1 : 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Outcome of one check from the words and the stalls seen on each read.
   function automatic void predict(input int t, input int sid, input int sts,
                                   input logic [31:0] idw, input logic [31:0] tsw,
                                   output int lat, output logic pass,
                                   output logic [31:0] st, output logic [31:0] cid,
                                   output logic [31:0] cts);
      bit to_id, to_ts, idm, tsm;
      to_id = (sid > t);
      to_ts = !to_id && (sts > t);
      cid   = to_id ? 32'd0 : idw;
      cts   = (to_id || to_ts) ? 32'd0 : tsw;
      idm   = (cid != EXP_ID);
      tsm   = !to_id && !to_ts && (tsw != EXP_TS);
      pass  = !(to_id || to_ts || idm || tsm);
      lat   = to_id ? t + 1 : (sid + 1) + (to_ts ? t + 1 : sts + 1);
      st    = 32'd1 + (pass ? 32'd2 : 32'd0) + (idm ? 32'd4 : 32'd0) + (tsm ? 32'd8 : 32'd0)
              + ((to_id || to_ts) ? 32'd16 : 32'd0);
   endfunction

   task automatic rd(input bit sel_b, input logic [1:0] adr, output logic [31:0] d);
      a_s_address = adr;
      b_s_address = adr;
      #1;
      d = sel_b ? b_s_rdata : a_s_rdata;
   endtask

   task automatic wr(input bit sel_b, input logic [31:0] data);
      if (sel_b) begin
         b_s_address = 2'd3; b_s_wdata = data; b_s_write = 1'b1;
      end else begin
         a_s_address = 2'd3; a_s_wdata = data; a_s_write = 1'b1;
      end
      @(posedge clock); #1;
      a_s_write = 1'b0;
      b_s_write = 1'b0;
   endtask

   task automatic wait_done(input bit sel_b, output int n);
      n = 0;
      do begin
         @(posedge clock); #1; n++;
      end while (!(sel_b ? b_done : a_done) && n < 2000);
   endtask

   task automatic wait_fall(input int start, output int n);
      n = start;
      do begin
         @(posedge clock); #1; n++;
      end while (b_done && n < 100);
   endtask

   task automatic expect_check(input bit sel_b, input string tag, input int base,
                               inout logic irq_m);
      int lat, n;
      logic pass;
      logic [31:0] st, cid, cts, d;
      predict(sel_b ? TB : TA, sel_b ? b_stall_id : a_stall_id, sel_b ? b_stall_ts : a_stall_ts,
              id_word, ts_word, lat, pass, st, cid, cts);
      irq_m = irq_m | !pass;
      wait_done(sel_b, n);
      check({tag, ".latency"}, 32'(n), 32'(base + lat));
      rd(sel_b, 2'd0, d); check({tag, ".status"}, d, st + (irq_m ? 32'd32 : 32'd0));
      rd(sel_b, 2'd1, d); check({tag, ".cap_id"}, d, cid);
      rd(sel_b, 2'd2, d); check({tag, ".cap_ts"}, d, cts);
      check({tag, ".pass_pin"}, {31'd0, sel_b ? b_pass : a_pass}, {31'd0, pass});
      check({tag, ".irq_pin"}, {31'd0, sel_b ? b_irq : a_irq}, {31'd0, irq_m});
      check({tag, ".m_read"}, {31'd0, sel_b ? b_m_read : a_m_read}, 32'd0);
      $display("check %s: edges=%0d status=0x%02h pass=%0d", tag, n, d[7:0], pass);
   endtask

   initial begin
      logic [31:0] d, ctrl;
      int n;

      // reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst.a_m_read", {31'd0, a_m_read}, 32'd0);
      check("rst.b_m_read", {31'd0, b_m_read}, 32'd0);
      check("rst.a_done", {31'd0, a_done}, 32'd0);
      check("rst.a_irq", {31'd0, a_irq}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         rd(1'b0, 2'(i), d);
         check("rst.csr", d, 32'd0);
      end

      // boot check with no stalls: done three edges after release
      reset_n = 1'b1;
      expect_check(1'b0, "a.boot", 1, irq_a);

      // timestamp mismatch, irq clear, then clear+restart on a still-failing image
      ts_word = EXP_TS + 32'd1;
      wr(1'b0, 32'h1);
      check("a.done_clears", {31'd0, a_done}, 32'd0);
      expect_check(1'b0, "a.ts_bad", 0, irq_a);
      wr(1'b0, 32'h2);
      irq_a = 1'b0;
      rd(1'b0, 2'd0, d);
      check("a.irq_clear.status", d, 32'h09);
      check("a.irq_clear.pin", {31'd0, a_irq}, 32'd0);
      wr(1'b0, 32'h3);
      check("a.both.irq_low", {31'd0, a_irq}, 32'd0);
      expect_check(1'b0, "a.both", 0, irq_a);

      // five stall cycles on each read
      ts_word = EXP_TS;
      a_stall_id = 5; a_stall_ts = 5;
      wr(1'b0, 32'h3);
      irq_a = 1'b0;
      expect_check(1'b0, "a.stall5", 0, irq_a);

      // restart written during RD_TS is ignored; restart in DONE repeats the result
      a_stall_id = 0; a_stall_ts = 6;
      wr(1'b0, 32'h1);
      @(posedge clock); #1;
      check("a.in_rd_ts", {31'd0, a_m_address}, 32'd1);
      wr(1'b0, 32'h1);
      expect_check(1'b0, "a.restart_ignored", -2, irq_a);
      wr(1'b0, 32'h1);
      check("a.rerun.done_clears", {31'd0, a_done}, 32'd0);
      expect_check(1'b0, "a.rerun", 0, irq_a);

      // randomized checks on the default instance
      for (int i = 0; i < 12; i++) begin
         id_word    = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom();
         ts_word    = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom();
         a_stall_id = ($urandom_range(0, 5) == 0) ? int'($urandom_range(254, 258)) : int'($urandom_range(0, 7));
         a_stall_ts = ($urandom_range(0, 5) == 0) ? int'($urandom_range(254, 258)) : int'($urandom_range(0, 7));
         ctrl = ($urandom_range(0, 1) != 0) ? 32'h3 : 32'h1;
         wr(1'b0, ctrl);
         if (ctrl[1]) irq_a = 1'b0;
         check("a.rand.done_clears", {31'd0, a_done}, 32'd0);
         expect_check(1'b0, "a.rand", 0, irq_a);
      end

      // reset pulse in RD_TS clears everything; the check then reruns from IDLE
      id_word = EXP_ID; ts_word = EXP_TS;
      a_stall_id = 0; a_stall_ts = 4;
      wr(1'b0, 32'h1);
      @(posedge clock); #1;
      reset_n = 1'b0;
      @(posedge clock); #1;
      check("a.pulse.m_read", {31'd0, a_m_read}, 32'd0);
      check("a.pulse.done", {31'd0, a_done}, 32'd0);
      check("a.pulse.irq", {31'd0, a_irq}, 32'd0);
      rd(1'b0, 2'd0, d); check("a.pulse.status", d, 32'd0);
      rd(1'b0, 2'd1, d); check("a.pulse.cap_id", d, 32'd0);
      a_stall_ts = 0;
      irq_a = 1'b0;
      reset_n = 1'b1;
      expect_check(1'b0, "a.after_pulse", 1, irq_a);

      // short-timeout instance: stuck waitrequest on the ID read
      reset_n = 1'b0;
      b_stall_id = 100000; b_stall_ts = 0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      irq_b = 1'b0;
      expect_check(1'b1, "b.timeout", 1, irq_b);

      // automatic recheck PB cycles after DONE entry; irq stays sticky
      b_stall_id = 0;
      wait_fall(0, n);
      check("b.recheck.delay", 32'(n), 32'(PB));
      expect_check(1'b1, "b.recheck", 0, irq_b);

      // irq clear landing on a failing DONE entry loses to the set
      wr(1'b1, 32'h2);
      irq_b = 1'b0;
      ts_word = EXP_TS ^ 32'h100;
      wait_fall(1, n);
      check("b.collide.delay", 32'(n), 32'(PB));
      @(posedge clock); #1;
      wr(1'b1, 32'h2);
      irq_b = 1'b1;
      check("b.collide.done", {31'd0, b_done}, 32'd1);
      check("b.collide.irq", {31'd0, b_irq}, 32'd1);
      rd(1'b1, 2'd0, d); check("b.collide.status", d, 32'h29);
      $display("check b.collide: status=0x%02h irq=%0d", d[7:0], b_irq);

      // randomized automatic rechecks with the short timeout
      for (int i = 0; i < 10; i++) begin
         id_word    = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom();
         ts_word    = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom();
         b_stall_id = int'($urandom_range(0, 6));
         b_stall_ts = int'($urandom_range(0, 6));
         if ($urandom_range(0, 1) != 0) begin
            wr(1'b1, 32'h2);
            irq_b = 1'b0;
            wait_fall(1, n);
         end else begin
            wait_fall(0, n);
         end
         check("b.rand.delay", 32'(n), 32'(PB));
         expect_check(1'b1, "b.rand", 0, irq_b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
